// File: rtl/serial_rx_pkg.sv
// Shared constants for the serial frame receiver and its future transmitter peer.
package serial_rx_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_RESYNC = 3'd4;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;
endpackage

// File: rtl/rx_shift_reg.sv
// Right-shifting payload register: serial bits enter at the MSB so an
// LSB-first stream lands in natural bit order after WIDTH shifts.
module rx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] sh_q;

  generate
    if (WIDTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sh_q <= '0;
        else if (en_i) sh_q <= sin_i;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sh_q <= '0;
        else if (en_i) sh_q <= {sin_i, sh_q[WIDTH-1:1]};
      end
    end
  endgenerate

  assign q_o = sh_q;
endmodule

// File: rtl/serial_frame_rx.sv
// One-bit-per-clock frame receiver: start(1), LSB-first payload, optional
// parity, stop(0); registered valid/parity_err/frame_err strobes.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);
  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             pbit_q, pbit_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             sh_en;
  logic [WIDTH-1:0] sh_q;

  rx_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (sh_en),
    .sin_i (d),
    .q_o   (sh_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    pbit_d  = pbit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    sh_en   = 1'b0;
    case (state_q)
      ST_IDLE: if (d) begin
        state_d = ST_DATA;
        cnt_d   = '0;
        par_d   = 1'b0;
        pbit_d  = 1'b0;
      end
      ST_DATA: begin
        sh_en = 1'b1;
        par_d = par_q ^ d;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        pbit_d  = d;
        state_d = ST_STOP;
      end
      ST_STOP: if (!d) begin
        data_d  = sh_q;
        valid_d = 1'b1;
        perr_d  = PARITY_EN && ((par_q ^ pbit_q) != PARITY_ODD);
        state_d = ST_IDLE;
      end else begin
        // Bad stop: hold data_out and wait for the line to drop before rearming.
        ferr_d  = 1'b1;
        state_d = ST_RESYNC;
      end
      ST_RESYNC: if (!d) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      pbit_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      pbit_q  <= pbit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);
endmodule
